// File: rtl/clock_pkg.sv
// Shared definitions for the clock/mode controller: mode encoding and field limits.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam int HOUR_LIMIT = 24;
  localparam int MIN_LIMIT  = 60;

  // Mode sequence wraps SET_SEC back to RUN.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo-N counter with increment, synchronous clear and same-cycle carry-out.
module bcd_mod_cnt #(
  parameter int N = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [3:0] MAX_TENS = 4'((N - 1) / 10);
  localparam logic [3:0] MAX_ONES = 4'((N - 1) % 10);

  logic at_max;

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  // Combinational so the next counter up the chain advances on the same edge.
  assign carry  = inc && !clr && at_max;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// 24-hour BCD clock with a RUN/SET_HOUR/SET_MIN/SET_SEC edit FSM and blinking field enables.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_up,
  input  logic       i_tick_sec,
  input  logic       i_tick_blink,
  output logic [3:0] hour10,
  output logic [3:0] hour0,
  output logic [3:0] min10,
  output logic [3:0] min0,
  output logic [3:0] sec10,
  output logic [3:0] sec0,
  output logic       dis_hour,
  output logic       dis_min,
  output logic       dis_sec,
  output logic [1:0] o_mode
);

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_HALF - 1);

  mode_e      state, state_nxt;
  logic       run, up_eff;
  logic       sec_inc, sec_clr, sec_carry;
  logic       min_inc, min_carry;
  logic       hour_inc, hour_carry_unused;
  logic [3:0] blink_cnt, blink_cnt_nxt;
  logic       blink_phase, blink_phase_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MODE_RUN;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (i_sw_mode) state_nxt = next_mode(state);
  end

  assign o_mode = state;
  assign run    = (state == MODE_RUN);
  // A mode step in the same cycle wins; the up pulse is dropped.
  assign up_eff = i_sw_up && !i_sw_mode && !run;

  // Carries only ripple in RUN, so edits never spill into the next field.
  assign sec_inc  = run && i_tick_sec;
  assign sec_clr  = up_eff && (state == MODE_SET_SEC);
  assign min_inc  = (run && sec_carry) || (up_eff && (state == MODE_SET_MIN));
  assign hour_inc = (run && min_carry) || (up_eff && (state == MODE_SET_HOUR));

  bcd_mod_cnt #(.N(MIN_LIMIT)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (sec_clr),
    .tens  (sec10),
    .ones  (sec0),
    .carry (sec_carry)
  );

  bcd_mod_cnt #(.N(MIN_LIMIT)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (min10),
    .ones  (min0),
    .carry (min_carry)
  );

  bcd_mod_cnt #(.N(HOUR_LIMIT)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .tens  (hour10),
    .ones  (hour0),
    .carry (hour_carry_unused)
  );

  // Any mode change or edit restarts the blink so the field is shown at once.
  always_comb begin
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    if ((state_nxt != state) || up_eff) begin
      blink_cnt_nxt   = 4'd0;
      blink_phase_nxt = 1'b1;
    end else if (i_tick_blink) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_nxt   = 4'd0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt   = blink_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= 4'd0;
      blink_phase <= 1'b1;
      dis_hour    <= 1'b1;
      dis_min     <= 1'b1;
      dis_sec     <= 1'b1;
    end else begin
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      dis_hour    <= (state_nxt != MODE_SET_HOUR) || blink_phase_nxt;
      dis_min     <= (state_nxt != MODE_SET_MIN)  || blink_phase_nxt;
      dis_sec     <= (state_nxt != MODE_SET_SEC)  || blink_phase_nxt;
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench: seconds-of-day reference model, directed scenarios, then random pulses.
module tb_clock_mode_ctrl;

  localparam int BH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_mode = 1'b0, sw_up = 1'b0, tick_sec = 1'b0, tick_blink = 1'b0;
  logic [3:0] hour10, hour0, min10, min0, sec10, sec0;
  logic       dis_hour, dis_min, dis_sec;
  logic [1:0] o_mode;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.BLINK_HALF(BH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sw_mode    (sw_mode),
    .i_sw_up      (sw_up),
    .i_tick_sec   (tick_sec),
    .i_tick_blink (tick_blink),
    .hour10       (hour10),
    .hour0        (hour0),
    .min10        (min10),
    .min0         (min0),
    .sec10        (sec10),
    .sec0         (sec0),
    .dis_hour     (dis_hour),
    .dis_min      (dis_min),
    .dis_sec      (dis_sec),
    .o_mode       (o_mode)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time kept as seconds since midnight, mode as 0..3.
  int m_t = 0, m_mode = 0, m_bcnt = 0;
  bit m_phase = 1'b1;

  always @(posedge clk or negedge rst_n) begin : model
    int t, md, bc, h, mi;
    bit ph;
    if (!rst_n) begin
      m_t <= 0; m_mode <= 0; m_bcnt <= 0; m_phase <= 1'b1;
    end else begin
      t = m_t; md = m_mode; bc = m_bcnt; ph = m_phase;
      if (md == 0 && tick_sec) t = (t + 1) % 86400;
      if (md != 0 && sw_up && !sw_mode) begin
        case (md)
          1: begin h = t / 3600; t = t - h * 3600 + ((h + 1) % 24) * 3600; end
          2: begin mi = (t / 60) % 60; t = t - mi * 60 + ((mi + 1) % 60) * 60; end
          default: t = t - t % 60;
        endcase
      end
      if (sw_mode) begin
        md = (md + 1) % 4; ph = 1'b1; bc = 0;
      end else if (md != 0 && sw_up) begin
        ph = 1'b1; bc = 0;
      end else if (tick_blink) begin
        bc++;
        if (bc == BH) begin bc = 0; ph = !ph; end
      end
      m_t <= t; m_mode <= md; m_bcnt <= bc; m_phase <= ph;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("hour10", hour10, (m_t / 3600) / 10);
      check("hour0",  hour0,  (m_t / 3600) % 10);
      check("min10",  min10,  ((m_t / 60) % 60) / 10);
      check("min0",   min0,   ((m_t / 60) % 60) % 10);
      check("sec10",  sec10,  (m_t % 60) / 10);
      check("sec0",   sec0,   (m_t % 60) % 10);
      check("o_mode", o_mode, m_mode);
      check("dis_hour", dis_hour, (m_mode == 1) ? int'(m_phase) : 1);
      check("dis_min",  dis_min,  (m_mode == 2) ? int'(m_phase) : 1);
      check("dis_sec",  dis_sec,  (m_mode == 3) ? int'(m_phase) : 1);
    end
  end

  task automatic step(input bit m, input bit u, input bit t, input bit b);
    sw_mode = m; sw_up = u; tick_sec = t; tick_blink = b;
    @(posedge clk);
    #1;
    sw_mode = 0; sw_up = 0; tick_sec = 0; tick_blink = 0;
  endtask

  task automatic check_time(input string name, input int h, input int mi, input int s);
    check({name, ".hour"}, hour10 * 10 + hour0, h);
    check({name, ".min"},  min10 * 10 + min0, mi);
    check({name, ".sec"},  sec10 * 10 + sec0, s);
  endtask

  task automatic check_idle(input string name);
    check({name, ".mode"}, o_mode, 0);
    check({name, ".dis"},  {dis_hour, dis_min, dis_sec}, 3'b111);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int exp_dis [4];
    exp_dis = '{1, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check_time("reset", 0, 0, 0);
    check_idle("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 3661 seconds -> 01:01:01
    for (int i = 0; i < 3661; i++) step(0, 0, 1, 0);
    check_time("run3661", 1, 1, 1);
    check_idle("run3661");

    // Edit boundaries starting from 00:00:42
    pulse_reset();
    check_time("rst2", 0, 0, 0);
    for (int i = 0; i < 42; i++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    check_time("run_up_ignored", 0, 0, 42);
    step(1, 0, 0, 0);
    check("set_hour.mode", o_mode, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      check($sformatf("blink%0d.dis_hour", i), dis_hour, exp_dis[i]);
      check($sformatf("blink%0d.dis_min_sec", i), {dis_min, dis_sec}, 2'b11);
    end
    for (int i = 0; i < 23; i++) step(0, 1, 0, 0);
    check_time("hour23", 23, 0, 42);
    step(0, 1, 0, 0);
    check_time("hour_wrap", 0, 0, 42);
    step(1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
    check_time("min59", 0, 59, 42);
    step(0, 1, 0, 0);
    check_time("min_wrap", 0, 0, 42);
    step(1, 1, 0, 0);
    check("mode_up.mode", o_mode, 3);
    check_time("mode_up", 0, 0, 42);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    check_time("sec_frozen", 0, 0, 42);
    step(0, 1, 0, 0);
    check_time("sec_clear", 0, 0, 0);

    // Preload 23:59:59 and roll over midnight
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("back_to_run", o_mode, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0);
    check_time("pre_midnight", 23, 59, 59);
    step(0, 0, 1, 0);
    check_time("midnight", 0, 0, 0);
    check_idle("midnight");

    // Reset while blanked in SET_SEC
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    check("set_sec.dis_sec", dis_sec, 0);
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0, 0);
    check_idle("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random pulses checked every cycle by the compare process
    for (int i = 0; i < 6000; i++) begin
      step(bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 3) == 0),
           bit'($urandom_range(0, 1) == 0), bit'($urandom_range(0, 2) == 0));
      if (i == 3000) pulse_reset();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
